// File: rtl/div_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | div_pkg : shared types and constants for the sequential divider    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int                   DIV_WIDTH   = 32;
    localparam int                   DIV_LATENCY = 34;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q  = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/div_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | div_seq_if : request/result bundle between controller and divider  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface div_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/div_seq_step.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | div_step : one restoring-division iteration (shift, trial, restore)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic [WIDTH-1:0] i_dvd,
    input  wire logic [WIDTH-1:0] i_dsr,
    output logic      [WIDTH-1:0] o_rem,
    output logic      [WIDTH-1:0] o_dvd
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_qbit;

    // The kept remainder is always below the divisor, so WIDTH bits hold it;
    // only the trial difference needs the extra sign bit.
    always_comb begin
        w_shift = {i_rem, i_dvd[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_dsr};
        w_qbit  = ~w_diff[WIDTH];
        o_rem   = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        o_dvd   = {i_dvd[WIDTH-2:0], w_qbit};
    end
endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | div_seq : 32-bit radix-2 restoring divider for DIV/DIVU            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input wire logic  clk,
    input wire logic  reset,
    div_seq_if.slave  bus
);
    localparam int                 C_CNT_W    = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(WIDTH - 1);

    div_state_t         r_state;
    div_state_t         w_next_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dsr;
    logic [WIDTH-1:0]   r_orig;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_zero;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_dvd_step;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dsr (r_dsr),
        .o_rem (w_rem_step),
        .o_dvd (w_dvd_step)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next_state = CALC;
            CALC:    if (r_cnt == '0) w_next_state = FIX;
            FIX:     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // 0x8000_0000 negates to itself, which is exactly its unsigned magnitude.
    always_comb begin
        w_a_neg = bus.is_signed & bus.dividend[WIDTH-1];
        w_b_neg = bus.is_signed & bus.divisor[WIDTH-1];
        w_a_abs = w_a_neg ? -bus.dividend : bus.dividend;
        w_b_abs = w_b_neg ? -bus.divisor  : bus.divisor;
        w_q_fix = r_zero ? WIDTH'(DIV_ZERO_Q) : (r_q_neg ? -r_dvd : r_dvd);
        w_r_fix = r_zero ? r_orig             : (r_r_neg ? -r_rem : r_rem);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_orig      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= (r_state == DONE);
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd   <= w_a_abs;
                        r_dsr   <= w_b_abs;
                        r_orig  <= bus.dividend;
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_zero  <= (bus.divisor == '0);
                        r_rem   <= '0;
                        r_cnt   <= C_CNT_LOAD;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_step;
                    r_dvd <= w_dvd_step;
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_div_zero  <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;
endmodule
`default_nettype wire
